uart_transmitter: RTL and testbench

//   Serial transmit end of the CPU's UART byte interface. Accepts bytes from the datapath on a

---
 rtl/uart_transmitter.sv | 156 +++++++++++++++
 tb/tb_uart_transmitter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: valid/ready byte intake, small FIFO, registered SOUT.
// Frames are sent back-to-back while the FIFO holds data.
module uart_transmitter #(
    parameter int ClockFreq = 50_000_000,
    parameter int BaudRate  = 115_200,
    parameter int FifoDepth = 4
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [7:0] DataIn,
    input  logic       DataInValid,
    output logic       DataInReady,
    output logic       SOUT,
    output logic       Busy
);

    localparam int SymbolEdgeTime = (ClockFreq + BaudRate / 2) / BaudRate;
    localparam int CNT_W = (SymbolEdgeTime > 1) ? $clog2(SymbolEdgeTime) : 1;
    localparam int PTR_W = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(SymbolEdgeTime - 1);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FifoDepth);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [7:0]         r_mem [FifoDepth];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic [CNT_W-1:0]   r_baud_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_sout;
    logic               w_sout_next;
    logic               w_push;
    logic               w_pop;
    logic               w_not_empty;
    logic               w_baud_tc;

    // Ready comes from the registered count only, so it never combinationally
    // depends on DataInValid.
    assign DataInReady = (r_count != FULL_CNT);
    assign w_push      = DataInValid && DataInReady;
    assign w_not_empty = (r_count != '0);
    assign w_baud_tc   = (r_baud_cnt == BAUD_LAST);
    assign SOUT        = r_sout;
    assign Busy        = (r_state != IDLE) || w_not_empty;

    // FIFO storage needs no reset: the pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= DataIn;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_sout_next  = 1'b1;
        case (r_state)
            IDLE: begin
                if (w_not_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = START;
                end
            end
            START: begin
                w_sout_next = 1'b0;
                if (w_baud_tc) begin
                    w_next_state = DATA;
                end
            end
            DATA: begin
                w_sout_next = r_shift[r_bit_idx];
                if (w_baud_tc && (r_bit_idx == 3'd7)) begin
                    w_next_state = STOP;
                end
            end
            STOP: begin
                // Chain straight into the next start bit when more data waits.
                if (w_baud_tc) begin
                    if (w_not_empty) begin
                        w_pop        = 1'b1;
                        w_next_state = START;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
        end else if (w_pop) begin
            r_shift    <= r_mem[r_rd_ptr];
            r_bit_idx  <= '0;
            r_baud_cnt <= '0;
        end else if (r_state != IDLE) begin
            r_baud_cnt <= w_baud_tc ? '0 : r_baud_cnt + 1'b1;
            if ((r_state == DATA) && w_baud_tc) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end
        end
    end

    // Line level lags the state by one cycle, keeping every symbol full length.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_sout <= 1'b1;
        end else begin
            r_sout <= w_sout_next;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: handshake scoreboard feeding a
// negedge-sampled frame decoder that checks start/data/stop timing.
module tb_uart_transmitter;

    localparam int SYM   = 16;
    localparam int FRAME = 10 * SYM;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] DataIn = 8'h00;
    logic       DataInValid = 1'b0;
    logic       DataInReady;
    logic       SOUT;
    logic       Busy;
    bit         clk_en = 1'b0;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    logic [7:0] exp_q[$];

    bit         m_active = 1'b0;
    int         m_off = 0;
    int         m_bi = 0;
    logic [7:0] m_byte = 8'h00;
    int         frames = 0;
    int         last_start = 0;
    int         starts[$];

    uart_transmitter #(
        .ClockFreq(16),
        .BaudRate (1),
        .FifoDepth(4)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .DataIn     (DataIn),
        .DataInValid(DataInValid),
        .DataInReady(DataInReady),
        .SOUT       (SOUT),
        .Busy       (Busy)
    );

    initial begin
        wait (clk_en);
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard push: every accepted handshake.
    always @(posedge CLK) begin
        if (reset && DataInValid && DataInReady) begin
            exp_q.push_back(DataIn);
            acc_cyc = cyc;
        end
    end

    // Frame decoder; offset 0 is the first negedge with SOUT low.
    always @(negedge CLK) begin
        cyc++;
        if (!reset) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (SOUT === 1'b0) begin
                m_active   = 1'b1;
                m_off      = 0;
                last_start = cyc;
                starts.push_back(cyc);
            end
        end else begin
            m_off++;
            if (m_off == SYM / 2) begin
                chk("start_bit", {31'd0, SOUT}, 32'd0);
            end else if (m_off >= 24 && m_off <= 136 && ((m_off - 24) % SYM) == 0) begin
                m_bi = (m_off - 24) / SYM;
                m_byte[m_bi[2:0]] = SOUT;
            end else if (m_off == 152) begin
                chk("stop_bit", {31'd0, SOUT}, 32'd1);
            end else if (m_off == FRAME - 1) begin
                chk("sb_has_entry", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    chk("frame_byte", {24'd0, m_byte}, {24'd0, exp_q.pop_front()});
                end
                frames++;
                m_active = 1'b0;
            end
        end
    end

    // Offer one byte; while not ready, present junk (0xC0..0xDF) to prove it is ignored.
    task automatic send(input logic [7:0] b, input bit junk);
        int n;
        n = 0;
        @(negedge CLK);
        DataInValid = 1'b1;
        while (!DataInReady && n < 1000) begin
            DataIn = junk ? (8'hC0 | 8'(n[4:0])) : b;
            @(negedge CLK);
            n++;
        end
        chk("send_ready", {31'd0, DataInReady}, 32'd1);
        DataIn = b;
        @(posedge CLK);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (frames < n && k < budget) begin
            @(negedge CLK);
            #1;
            k++;
        end
        chk("frames_reached", {31'd0, frames >= n}, 32'd1);
    endtask

    initial begin
        int f0;
        int s0;
        int e;
        int k;

        // Async reset with no clock running
        #1 reset = 1'b0;
        #1;
        chk("rst_sout",  {31'd0, SOUT},        32'd1);
        chk("rst_ready", {31'd0, DataInReady}, 32'd1);
        chk("rst_busy",  {31'd0, Busy},        32'd0);
        clk_en = 1'b1;
        repeat (3) @(negedge CLK);
        reset = 1'b1;
        repeat (3) @(negedge CLK);

        // Single frame 0xA5
        send(8'hA5, 1'b0);
        @(negedge CLK);
        DataInValid = 1'b0;
        #1;
        chk("a5_busy_during", {31'd0, Busy}, 32'd1);
        wait_frames(1, 400);
        chk("a5_latency", 32'(last_start - acc_cyc), 32'd3);
        @(negedge CLK);
        #1;
        chk("a5_busy_after", {31'd0, Busy}, 32'd0);
        chk("a5_sout_after", {31'd0, SOUT}, 32'd1);

        // Six bytes streamed; FIFO fills, sixth waits with junk on DataIn
        f0 = frames;
        s0 = starts.size();
        for (int b = 1; b <= 6; b++) begin
            if (b == 6) begin
                @(negedge CLK);
                #1;
                chk("full_ready_low", {31'd0, DataInReady}, 32'd0);
            end
            send(8'(b), 1'b1);
        end
        @(negedge CLK);
        DataInValid = 1'b0;
        wait_frames(f0 + 6, 2000);
        chk("stream_frames", 32'(frames - f0), 32'd6);
        chk("stream_sb_empty", 32'(exp_q.size()), 32'd0);
        if (starts.size() >= s0 + 6) begin
            for (int i = s0 + 1; i < s0 + 6; i++) begin
                chk("stream_gap", 32'(starts[i] - starts[i-1]), 32'(FRAME));
            end
        end
        @(negedge CLK);
        #1;
        chk("stream_busy_after", {31'd0, Busy}, 32'd0);

        // DataIn toggling without valid
        f0 = frames;
        e = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            DataIn = 8'($urandom);
            #1;
            if (SOUT !== 1'b1 || Busy !== 1'b0) e++;
        end
        chk("idle_toggle_bad", 32'(e), 32'd0);
        chk("idle_toggle_frames", 32'(frames), 32'(f0));

        // Reset in data bit 3 of 0x3C with two bytes queued
        send(8'h3C, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        @(negedge CLK);
        DataInValid = 1'b0;
        k = 0;
        while (!(m_active && m_off == 72) && k < 400) begin
            @(negedge CLK);
            #1;
            k++;
        end
        chk("rst_mid_reached", {31'd0, m_active && m_off == 72}, 32'd1);
        chk("rst_mid_busy_pre", {31'd0, Busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_sout",  {31'd0, SOUT},        32'd1);
        chk("rst_mid_ready", {31'd0, DataInReady}, 32'd1);
        chk("rst_mid_busy",  {31'd0, Busy},        32'd0);
        exp_q.delete();
        repeat (3) @(negedge CLK);
        reset = 1'b1;
        f0 = frames;
        e = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            #1;
            if (SOUT !== 1'b1 || Busy !== 1'b0) e++;
        end
        chk("post_rst_quiet", 32'(e), 32'd0);
        chk("post_rst_frames", 32'(frames), 32'(f0));
        send(8'h55, 1'b0);
        @(negedge CLK);
        DataInValid = 1'b0;
        wait_frames(f0 + 1, 400);
        repeat (40) @(negedge CLK);
        #1;
        chk("p55_frames", 32'(frames - f0), 32'd1);
        chk("p55_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("p55_busy_after", {31'd0, Busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
